// File: rtl/i2c_seq_writer.sv
// I2C write sequencer: START, {DEV_ADDR,W}, CTRL_BYTE, LEN ROM bytes, STOP; one FSM step per clk2.
// Define I2C_SEQ_RETRY_EN to restart the transfer after a NACK, up to MAX_RETRY times.
module i2c_seq_writer #(
   parameter logic [6:0] DEV_ADDR  = 7'h3D,
   parameter logic [7:0] CTRL_BYTE = 8'h00,
   parameter int         LEN       = 41,
   parameter int         AW        = 7,
   parameter int         MAX_RETRY = 3
) (
   input  logic          clk2,
   input  logic          reset,
   input  logic          start,
   input  logic          sda,
   input  logic [7:0]    rom_data,
   output logic [AW-1:0] rom_addr,
   output logic          sda_w,
   output logic          ctrl_d,
   output logic          ctrl_h,
   output logic          ctrl_l,
   output logic          busy,
   output logic          done,
   output logic          nack_err
);
   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK_A, CTRL, ACK_C, DATA, ACK_D, STOP1, STOP2
   } state_t;

   localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b0};
   localparam logic [AW-1:0] LAST      = AW'(LEN - 1);

   state_t        state, state_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [AW-1:0] rom_addr_nx;
   logic          nacked, nacked_nx;
   logic          nack_err_nx, done_nx;
   logic          retry_ok;

`ifdef I2C_SEQ_RETRY_EN
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RW-1:0] retry_cnt;
   logic          retry_clr, retry_inc;

   assign retry_ok  = (int'(retry_cnt) < MAX_RETRY);
   assign retry_clr = (state == IDLE) && start;
   assign retry_inc = (state == STOP2) && nacked && retry_ok;

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset)         retry_cnt <= '0;
      else if (retry_clr) retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
   end
`else
   assign retry_ok = 1'b0;
`endif

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         bit_cnt  <= 3'd7;
         rom_addr <= '0;
         nacked   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         nack_err <= 1'b0;
      end else begin
         state    <= state_nx;
         bit_cnt  <= bit_cnt_nx;
         rom_addr <= rom_addr_nx;
         nacked   <= nacked_nx;
         busy     <= (state_nx != IDLE);
         done     <= done_nx;
         nack_err <= nack_err_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      rom_addr_nx = rom_addr;
      nacked_nx   = nacked;
      nack_err_nx = nack_err;
      done_nx     = 1'b0;
      ctrl_d      = 1'b1;
      sda_w       = 1'b1;
      ctrl_h      = 1'b1;
      ctrl_l      = 1'b1;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx    = START;
               nack_err_nx = 1'b0;
            end
         end
         START: begin
            sda_w       = 1'b0;
            nacked_nx   = 1'b0;
            rom_addr_nx = '0;
            state_nx    = ADDR;
         end
         ADDR, CTRL, DATA: begin
            {ctrl_h, ctrl_l} = 2'b00;
            if (state == ADDR)      sda_w = ADDR_BYTE[bit_cnt];
            else if (state == CTRL) sda_w = CTRL_BYTE[bit_cnt];
            else                    sda_w = rom_data[bit_cnt];
            if (bit_cnt == 3'd0) begin
               bit_cnt_nx = 3'd7;
               if (state == ADDR)      state_nx = ACK_A;
               else if (state == CTRL) state_nx = ACK_C;
               else                    state_nx = ACK_D;
            end else begin
               bit_cnt_nx = bit_cnt - 3'd1;
            end
         end
         ACK_A, ACK_C, ACK_D: begin
            ctrl_d           = 1'b0;
            sda_w            = 1'b0;
            {ctrl_h, ctrl_l} = 2'b00;
            // sda is the slave's ACK bit, sampled on the edge that leaves this state
            if (sda) begin
               nacked_nx   = 1'b1;
               rom_addr_nx = '0;
               state_nx    = STOP1;
            end else if (state == ACK_A) begin
               state_nx = CTRL;
            end else if (state == ACK_C) begin
               state_nx = DATA;
            end else if (rom_addr == LAST) begin
               rom_addr_nx = '0;
               state_nx    = STOP1;
            end else begin
               rom_addr_nx = rom_addr + 1'b1;
               state_nx    = DATA;
            end
         end
         STOP1: begin
            sda_w            = 1'b0;
            {ctrl_h, ctrl_l} = 2'b10;
            state_nx         = STOP2;
         end
         STOP2: begin
            {ctrl_h, ctrl_l} = 2'b10;
            if (nacked && retry_ok) begin
               state_nx = START;
            end else begin
               state_nx    = IDLE;
               done_nx     = 1'b1;
               nack_err_nx = nacked;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_i2c_seq_writer.sv
// Scoreboard bench for i2c_seq_writer: a byte-level model queues expected bus bytes and
// per-transfer results; a monitor decodes the bus and a slave model drives ACK/NACK.
`timescale 1ns/1ps
module tb_i2c_seq_writer;
   localparam int         LEN       = 41;
   localparam int         AW        = 7;
   localparam int         MAX_RETRY = 3;
   localparam logic [7:0] ADDR_B    = 8'h7A;
   localparam logic [7:0] CTRL_B    = 8'hC5;
`ifdef I2C_SEQ_RETRY_EN
   localparam int RETRIES = MAX_RETRY;
`else
   localparam int RETRIES = 0;
`endif

   logic          clk2 = 1'b0, reset = 1'b1, start = 1'b0, sda = 1'b1;
   logic [7:0]    rom_data;
   logic [AW-1:0] rom_addr;
   logic          sda_w, ctrl_d, ctrl_h, ctrl_l, busy, done, nack_err;
   logic [7:0]    rom [0:(1<<AW)-1];

   typedef struct {
      int cycles;
      int starts;
      bit err;
   } txn_t;

   txn_t       exp_txn[$];
   logic [7:0] exp_bytes[$];
   int         tests = 0, fails = 0;
   int         plan_byte = -1;
   bit         plan_persist = 1'b0;

   i2c_seq_writer #(.DEV_ADDR(7'h3D), .CTRL_BYTE(CTRL_B), .LEN(LEN), .AW(AW),
                    .MAX_RETRY(MAX_RETRY)) dut (
      .clk2(clk2), .reset(reset), .start(start), .sda(sda), .rom_data(rom_data),
      .rom_addr(rom_addr), .sda_w(sda_w), .ctrl_d(ctrl_d), .ctrl_h(ctrl_h),
      .ctrl_l(ctrl_l), .busy(busy), .done(done), .nack_err(nack_err));

   always #5 clk2 = ~clk2;
   assign rom_data = rom[rom_addr];

   function automatic bit is_bit();   return ctrl_d && !ctrl_h && !ctrl_l;           endfunction
   function automatic bit is_ack();   return !ctrl_d && !ctrl_h && !ctrl_l;          endfunction
   function automatic bit is_start(); return ctrl_d && !sda_w && ctrl_h && ctrl_l;   endfunction
   function automatic bit is_stop2(); return ctrl_d && sda_w && ctrl_h && !ctrl_l;   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      tests++;
      fails++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: attempt k NACKs byte nb (0=addr,1=ctrl,2+i=data i) if persist or k==0.
   task automatic expect_txn(input int nb, input bit persist);
      txn_t t;
      int   sent;
      bit   nk;
      t.cycles = 0; t.starts = 0; t.err = 1'b0;
      for (int k = 0; k <= RETRIES; k++) begin
         nk   = (nb >= 0) && (persist || k == 0);
         sent = nk ? nb + 1 : LEN + 2;
         for (int b = 0; b < sent; b++)
            exp_bytes.push_back(b == 0 ? ADDR_B : (b == 1 ? CTRL_B : rom[b-2]));
         t.cycles += 1 + 9 * sent + 2;
         t.starts++;
         t.err = nk;
         if (!nk) break;
      end
      exp_txn.push_back(t);
   endtask

   // Slave: ACKs everything except the planned byte.
   int s_attempt = 0, s_byte = 0;
   always @(negedge clk2) begin
      sda = 1'b1;
      if (!reset || !busy) begin
         s_attempt = 0;
         s_byte    = 0;
      end else if (is_start()) begin
         s_attempt++;
         s_byte = 0;
      end else if (is_ack()) begin
         sda = (s_byte == plan_byte && (plan_persist || s_attempt == 1));
         s_byte++;
      end
   end

   // Monitor
   int         m_cyc = 0, m_starts = 0, m_stops = 0, m_nbits = 0;
   logic [7:0] m_sh = 8'h00, m_e;
   bit         m_prev_done = 1'b0;
   txn_t       m_t;
   always @(negedge clk2) begin
      if (!reset) begin
         m_cyc = 0; m_starts = 0; m_stops = 0; m_nbits = 0; m_prev_done = 1'b0;
      end else begin
         if (busy) m_cyc++;
         if (is_start()) m_starts++;
         if (is_stop2()) m_stops++;
         if (is_bit()) begin
            m_sh = {m_sh[6:0], sda_w};
            m_nbits++;
            if (m_nbits == 8) begin
               m_nbits = 0;
               if (exp_bytes.size() == 0) flag("unexpected_byte");
               else begin
                  m_e = exp_bytes.pop_front();
                  chk("bus_byte", m_sh, m_e);
               end
            end
         end
         if (done) begin
            chk("done_width", m_prev_done, 0);
            if (exp_txn.size() == 0) flag("unexpected_done");
            else begin
               m_t = exp_txn.pop_front();
               chk("busy_cycles", m_cyc, m_t.cycles);
               chk("start_count", m_starts, m_t.starts);
               chk("stop_count", m_stops, m_t.starts);
               chk("nack_err", nack_err, m_t.err);
               chk("rom_addr_end", rom_addr, 0);
               chk("partial_bits", m_nbits, 0);
            end
            m_cyc = 0; m_starts = 0; m_stops = 0;
         end
         m_prev_done = done;
      end
   end

   task automatic wait_done();
      int n = 0;
      while (!done && n < 5000) begin
         @(negedge clk2);
         n++;
      end
      if (!done) flag("done_timeout");
   endtask

   task automatic kick(input int nb, input bit persist);
      expect_txn(nb, persist);
      plan_byte = nb; plan_persist = persist;
      @(negedge clk2); start = 1'b1;
      @(negedge clk2); start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("nack_err_cleared", nack_err, 0);
   endtask

   task automatic run(input int nb, input bit persist);
      kick(nb, persist);
      wait_done();
      @(negedge clk2);
   endtask

   task automatic fill_rom();
      for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
   endtask

   initial begin
      int n;
      fill_rom();
      #1 reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_nack_err", nack_err, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_bus", {ctrl_d, sda_w, ctrl_h, ctrl_l}, 4'b1111);
      repeat (2) @(negedge clk2);
      reset = 1'b1;

      run(-1, 1'b0);              // full ACK
      run(0, 1'b1);               // address NACK
      run(7, 1'b1);               // NACK on data byte 5, every attempt
      run(1, 1'b0);               // NACK at control byte, first attempt only
      for (int r = 0; r < 5; r++) begin
         fill_rom();
         run(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, LEN + 1)),
             1'($urandom_range(0, 1)));
      end

      // start pulsed mid-transfer is ignored
      kick(-1, 1'b0);
      repeat (100) @(negedge clk2);
      start = 1'b1;
      @(negedge clk2); start = 1'b0;
      wait_done();
      @(negedge clk2);
      chk("no_restart", busy, 0);

      // start held high: back-to-back with a single IDLE cycle
      expect_txn(-1, 1'b0);
      expect_txn(-1, 1'b0);
      plan_byte = -1;
      @(negedge clk2); start = 1'b1;
      @(negedge clk2);
      wait_done();
      @(negedge clk2);
      chk("b2b_gap", busy, 1);
      start = 1'b0;
      wait_done();
      @(negedge clk2);

      // asynchronous reset inside DATA byte 10
      kick(-1, 1'b0);
      n = 0;
      while (rom_addr != 10 && n < 2000) begin
         @(negedge clk2);
         n++;
      end
      if (rom_addr != 10) flag("reach_byte10_timeout");
      repeat (3) @(negedge clk2);
      @(posedge clk2);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_bus", {ctrl_d, sda_w, ctrl_h, ctrl_l}, 4'b1111);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rom_addr", rom_addr, 0);
      chk("mid_rst_done", done, 0);
      exp_bytes.delete();
      exp_txn.delete();
      @(negedge clk2);
      @(posedge clk2);
      #2 reset = 1'b1;
      run(-1, 1'b0);

      repeat (5) @(negedge clk2);
      chk("bytes_left", exp_bytes.size(), 0);
      chk("txns_left", exp_txn.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
